// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Holds the FSM state encoding and the grant encoding used by the arbiter and its selector.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

    localparam int CNT_W = 3;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin selector: one-hot grant (bit0 fetch, bit1 data).
// Latency: combinational. Backpressure: none; a tie goes to the side not granted last.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_t       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == GNT_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store ports.
// Latency: read ack LAT+1 cycles after grant edge's cycle, store ack 2 cycles after request.
// Backpressure: requesters hold req until their one-cycle ack; stall covers the wait.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT = 2,
    parameter int AW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          stall
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    gnt_t             last;
    gnt_t             sel;
    logic [AW-1:0]    addr_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [31:0]      if_rdata_q;
    logic [31:0]      d_rdata_q;
    logic [1:0]       req_eff;
    logic [1:0]       gnt;
    logic             grant;
    logic             access_done;

    assign if_ack   = (state == RESP) && (sel == GNT_IF);
    assign d_ack    = (state == RESP) && (sel == GNT_D);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign stall    = (if_req & ~if_ack) | (d_req & ~d_ack);

    // The requester being acked this cycle must not be granted again off its stale req.
    assign req_eff = {d_req & ~d_ack, if_req & ~if_ack};

    arb_rr2 u_rr (
        .req  (req_eff),
        .last (last),
        .gnt  (gnt)
    );

    assign grant       = (state != ACCESS) && (gnt != 2'b00);
    assign access_done = (state == ACCESS) && (we_q || (cnt == LAT_LAST));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            IDLE, RESP: state_nxt = grant ? ACCESS : IDLE;
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (access_done) begin
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            last       <= GNT_D;
            sel        <= GNT_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant) begin
                cnt <= '0;
                if (gnt[0]) begin
                    sel     <= GNT_IF;
                    last    <= GNT_IF;
                    addr_q  <= if_addr;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                end else begin
                    sel     <= GNT_D;
                    last    <= GNT_D;
                    addr_q  <= d_addr;
                    we_q    <= d_we;
                    wdata_q <= d_we ? d_wdata : '0;
                end
            end else if ((state == ACCESS) && !access_done) begin
                cnt <= cnt + CNT_W'(1);
            end
            // Read data lands in the port register on the edge into RESP, so it is valid with ack.
            if (access_done && !we_q) begin
                if (sel == GNT_IF) begin
                    if_rdata_q <= mem_rdata;
                end else begin
                    d_rdata_q <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 (LAT=2) is scoreboarded; instances 1..3 (LAT=3,1,7) cover latency.
module tb_mem_arbiter;

    localparam int N = 4;

    function automatic int lat_of(input int g);
        case (g)
            0:       lat_of = 2;
            1:       lat_of = 3;
            2:       lat_of = 1;
            default: lat_of = 7;
        endcase
    endfunction

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        mem_model = a ^ 32'h0050_0283;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        if_ack_a    [N];
    logic [31:0] if_rdata_a  [N];
    logic        d_ack_a     [N];
    logic [31:0] d_rdata_a   [N];
    logic        mem_en_a    [N];
    logic        mem_we_a    [N];
    logic [31:0] mem_addr_a  [N];
    logic [31:0] mem_wdata_a [N];
    logic [31:0] mem_rdata_a [N];
    logic        stall_a     [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = lat_of(g);
        logic [2:0] en_run;

        mem_arbiter #(.LAT(L), .AW(32)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_ack    (if_ack_a[g]),
            .if_rdata  (if_rdata_a[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_ack     (d_ack_a[g]),
            .d_rdata   (d_rdata_a[g]),
            .mem_en    (mem_en_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_rdata (mem_rdata_a[g]),
            .stall     (stall_a[g])
        );

        // Memory returns good data only in the LAT-th cycle of an enable run.
        always_ff @(posedge clk) en_run <= mem_en_a[g] ? en_run + 3'd1 : 3'd0;
        assign mem_rdata_a[g] = (mem_en_a[g] && en_run == 3'(L - 1)) ?
                                mem_model(mem_addr_a[g]) : 32'hBAD0_BAD0;
    end

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat_cyc;
        logic [31:0] exp_rdata;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[6];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   sb_on = 1'b0;
    bit   saw_if;
    bit   saw_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit port, input logic [31:0] rdata, input int due);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.due   = due;
        sbq.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        saw_if = if_ack_a[0];
        saw_d  = d_ack_a[0];
        check("one_ack", {31'b0, saw_if & saw_d}, 32'd0);
        check("stall_at_ack", {31'b0, stall_a[0]},
              {31'b0, (if_req && !saw_if) || (d_req && !saw_d)});
        check("mem_en_at_ack", {31'b0, mem_en_a[0]}, 32'd0);
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b want none (cycle %0d)",
                     saw_if, saw_d, cyc);
        end else begin
            e = sbq.pop_front();
            check("ack_port", {31'b0, saw_d}, {31'b0, e.port});
            check("ack_cycle", cyc, e.due);
            check("ack_rdata", e.port ? d_rdata_a[0] : if_rdata_a[0], e.rdata);
        end
    endtask

    task automatic tick();
        saw_if = 1'b0;
        saw_d  = 1'b0;
        if (sb_on && (if_ack_a[0] || d_ack_a[0])) monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (if_req || d_req); i++) begin
            tick();
            if (saw_if) if_req = 1'b0;
            if (saw_d)  d_req  = 1'b0;
        end
        check("drain_done", {30'b0, if_req, d_req}, 32'd0);
        if_req = 1'b0;
        d_req  = 1'b0;
        check("sb_empty", sbq.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        sbq.delete();
    endtask

    initial begin
        int          c0;
        int          got;
        logic [31:0] rd;

        vt[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         3, 32'h0050_0293};
        vt[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 2, 32'h0000_0000};
        vt[2] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         3, 32'h0050_02C7};
        vt[3] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         3, 32'h0050_1283};
        vt[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 2, 32'h0050_02C7};
        vt[5] = '{1'b1, 1'b0, 32'h000A_BCD0, 32'h0,         3, 32'h005A_BE53};

        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        do_reset();
        #1;
        check("rst_if_ack",   {31'b0, if_ack_a[0]}, 32'd0);
        check("rst_d_ack",    {31'b0, d_ack_a[0]},  32'd0);
        check("rst_mem_en",   {31'b0, mem_en_a[0]}, 32'd0);
        check("rst_mem_addr", mem_addr_a[0],        32'd0);
        check("rst_if_rdata", if_rdata_a[0],        32'd0);
        check("rst_d_rdata",  d_rdata_a[0],         32'd0);
        check("rst_stall",    {31'b0, stall_a[0]},  32'd0);

        // Single-requester transactions on the LAT=2 instance.
        sb_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c0 = cyc;
            if (vt[i].is_d) begin
                d_req = 1'b1; d_we = vt[i].we; d_addr = vt[i].addr; d_wdata = vt[i].wdata;
            end else begin
                if_req = 1'b1; if_addr = vt[i].addr;
            end
            push(vt[i].is_d, vt[i].exp_rdata, c0 + vt[i].lat_cyc);
            #1;
            check("stall_req", {31'b0, stall_a[0]}, 32'd1);
            tick();
            // Live inputs change after the grant; memory must keep the captured request.
            if_addr = ~vt[i].addr;
            d_addr  = ~vt[i].addr;
            d_wdata = ~vt[i].wdata;
            #1;
            check("acc_mem_en",   {31'b0, mem_en_a[0]}, 32'd1);
            check("acc_mem_we",   {31'b0, mem_we_a[0]}, {31'b0, vt[i].we});
            check("acc_mem_addr", mem_addr_a[0],        vt[i].addr);
            if (vt[i].we) check("acc_mem_wdata", mem_wdata_a[0], vt[i].wdata);
            drain(20);
            tick();
        end

        // Request dropped mid-access still completes.
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h80;
        push(1'b0, 32'h0050_0203, c0 + 3);
        tick();
        if_req = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("drop_sb_empty", sbq.size(), 32'd0);

        // Tie after reset: fetch first, then data with no idle bubble.
        do_reset();
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        push(1'b0, 32'h0050_0293, c0 + 3);
        push(1'b1, 32'h0050_02C7, c0 + 6);
        drain(30);

        // A lone fetch makes fetch the last grantee, so the next tie goes to data.
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h10;
        push(1'b0, 32'h0050_0293, c0 + 3);
        drain(20);
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h000A_BCD0;
        push(1'b1, 32'h005A_BE53, c0 + 3);
        push(1'b0, 32'h0050_1283, c0 + 6);
        drain(30);

        // Reset in the second access cycle abandons the read.
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        tick();
        rst = 1'b0;
        if_req = 1'b0;
        tick();
        #1;
        check("mid_rst_if_ack",    {31'b0, if_ack_a[0]}, 32'd0);
        check("mid_rst_mem_en",    {31'b0, mem_en_a[0]}, 32'd0);
        check("mid_rst_mem_we",    {31'b0, mem_we_a[0]}, 32'd0);
        check("mid_rst_mem_addr",  mem_addr_a[0],        32'd0);
        check("mid_rst_mem_wdata", mem_wdata_a[0],       32'd0);
        check("mid_rst_if_rdata",  if_rdata_a[0],        32'd0);
        rst = 1'b1;
        tick();
        tick();
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        push(1'b0, 32'h0050_02A3, c0 + 3);
        push(1'b1, 32'h0050_02B3, c0 + 6);
        drain(30);

        // Latency sweep on the LAT=3, 1, 7 instances.
        sb_on = 1'b0;
        for (int g = 1; g < N; g++) begin
            do_reset();
            c0 = cyc;
            got = -1;
            rd = '0;
            if_req = 1'b1; if_addr = 32'h30;
            for (int k = 0; k < 20; k++) begin
                #1;
                if (if_ack_a[g]) begin
                    got = cyc - c0;
                    rd  = if_rdata_a[g];
                    break;
                end
                tick();
            end
            if_req = 1'b0;
            check("lat_ack_cycle", got, lat_of(g) + 1);
            check("lat_rdata", rd, 32'h0050_02B3);
        end

        // Stall on a held load at LAT=3.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("lat3_stall", {31'b0, stall_a[1]}, {31'b0, k < 4});
            check("lat3_d_ack", {31'b0, d_ack_a[1]}, {31'b0, k == 4});
            if (k == 4) check("lat3_d_rdata", d_rdata_a[1], 32'h0050_02B3);
            tick();
        end
        d_req = 1'b0;
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
